fetch_redirect_stage: RTL and testbench
=======================================

// Module: fetch_redirect_stage
// PURPOSE
//   Consumer side of the branch/jump control-hazard protocol: owns the PC and the IF/ID pipeline register.
//   Fetches from a single-outstanding instruction memory and applies redirects (EX taken branch, ID jump).
//   Squashes wrong-path in-flight responses, inserts NOP bubbles into IF/ID and raises the ID/EX flush.
// PARAMETERS
//   XLEN      32            PC / address width
//   RESET_PC  32'h00000000  first fetch address after reset
//   NOP_INSTR 32'h00000013  encoding written into IF/ID on bubble/flush
// PORTS
//   clk          in   1     rising-edge clock
//   rst_n        in   1     asynchronous reset, active-low
//   stall        in   1     load-use stall: hold IF/ID contents
//   br_taken     in   1     EX branch resolved taken (branch & zero)
//   br_target    in   XLEN  branch target
//   jump         in   1     ID stage decoded jump
//   jump_target  in   XLEN  jump target
//   imem_req     out  1     fetch request valid
//   imem_addr    out  XLEN  fetch address (= pc)
//   imem_gnt     in   1     request accepted this cycle
//   imem_rvalid  in   1     response valid (in order, 1+ cycles after gnt)
//   imem_rdata   in   32    response instruction
//   if_id_pc     out  XLEN  IF/ID PC
//   if_id_instr  out  32    IF/ID instruction
//   if_id_valid  out  1     IF/ID holds a real instruction
//   id_ex_flush  out  1     comb: bubble ID/EX this cycle (= br_taken)
//   stat_br_cnt, stat_jmp_cnt, stat_sq_cnt  out 16 each  redirect/squash counters (see CONFIGURATION)
// BEHAVIOUR
//   Reset (async, rst_n=0): state=BOOT, pc=RESET_PC, if_id_pc=0, if_id_instr=NOP_INSTR,
//     if_id_valid=0, skid empty, counters=0; imem_req=0. Reset mid-transaction drops any outstanding response.
//   redirect = br_taken | jump; target = br_taken ? br_target : jump_target (branch wins: older instr).
//   Targets have bits[1:0] forced to 0; pc+4 wraps modulo 2^XLEN.
//   States:
//     BOOT   : imem_req=0; next cycle -> FETCH.
//     FETCH  : imem_req = ~redirect (comb), imem_addr=pc. gnt -> WAIT, pc_req<=pc.
//              redirect -> pc<=target, stay FETCH (no request issued that cycle).
//     WAIT   : imem_req=0. rvalid & ~redirect & ~stall -> IF/ID<={pc_req,rdata,1}, pc<=pc_req+4, -> FETCH.
//              rvalid & ~redirect & stall -> skid<={pc_req,rdata}, -> HOLD.
//              redirect & ~rvalid -> pc<=target, -> SQUASH.  redirect & rvalid -> drop, pc<=target, -> FETCH.
//     SQUASH : imem_req=0; discard response. rvalid -> FETCH. A further redirect overwrites pc (latest target).
//     HOLD   : imem_req=0. ~stall -> IF/ID<=skid (valid=1), pc<=skid_pc+4, -> FETCH.
//              redirect -> drop skid, pc<=target, -> FETCH.
//   IF/ID update priority each cycle: redirect > stall > new response > bubble.
//     redirect: if_id_instr<=NOP_INSTR, if_id_valid<=0 (flush overrides stall).
//     stall (no redirect): hold all IF/ID fields.
//     no stall, no response written: if_id_valid<=0, if_id_instr<=NOP_INSTR, if_id_pc held.
//   Latency: gnt at cycle n, rvalid at n+k -> IF/ID valid at n+k+1; redirect -> request to target next cycle.
//   At most one outstanding request; imem_req never asserted in WAIT/SQUASH/HOLD/BOOT.
// CONFIGURATION
//   FETCH_REDIRECT_STATS_EN defined: stat_br_cnt += 1 per cycle br_taken=1, stat_jmp_cnt += 1 per cycle
//     jump=1 & br_taken=0, stat_sq_cnt += 1 per dropped response or skid entry; all saturate at 16'hFFFF.
//   Undefined: counter logic removed, stat_* ports present and tied to 16'h0000.
// TESTING
//   Reset, imem 1-cycle latency, instrs at 0x0/0x4/0x8 -> imem_addr 0,4,8; if_id_valid=1 with pc 0,4,8 in order.
//   br_taken=1, br_target=0x40 while WAIT for 0x8 -> id_ex_flush=1, rdata of 0x8 dropped, if_id_valid=0, next imem_addr=0x40.
//   jump=1 & br_taken=1 same cycle (targets 0x80/0x40) -> next fetch 0x40; stat_br_cnt=1, stat_jmp_cnt=0.
//   stall=1 3 cycles while response for 0x10 arrives -> IF/ID held, HOLD; stall drops -> if_id_pc=0x10, valid=1.
//   br_taken during HOLD under stall -> skid dropped, IF/ID valid=0, fetch target; stat_sq_cnt=1.
//   rst_n low in WAIT, late rvalid after release -> ignored; BOOT then fetch RESET_PC.

Source files
------------

// File: rtl/fetch_redirect_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_redirect_stage_if
//   Instruction-memory request/response bus between the fetch stage and a
//   single-outstanding instruction memory.
//
//   Signals
//     req     fetch request valid                (fetch -> memory)
//     addr    fetch address, XLEN bits           (fetch -> memory)
//     gnt     request accepted this cycle        (memory -> fetch)
//     rvalid  response valid, in order           (memory -> fetch)
//     rdata   response instruction, 32 bits      (memory -> fetch)
//
//   Modports
//     master  used by the fetch stage (drives req/addr)
//     slave   used by the memory (drives gnt/rvalid/rdata)
// ---------------------------------------------------------------------------
interface fetch_redirect_stage_if #(
    parameter int unsigned XLEN = 32
);
    logic            req;
    logic [XLEN-1:0] addr;
    logic            gnt;
    logic            rvalid;
    logic [31:0]     rdata;

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata
    );
endinterface

// File: rtl/fetch_redirect_stage.sv
// ---------------------------------------------------------------------------
// fetch_redirect_stage
//   Owns the PC and the IF/ID pipeline register. It fetches from a
//   single-outstanding instruction memory and applies control-flow
//   redirects: a taken branch resolved in EX, or a jump decoded in ID.
//   Responses that belong to the wrong path are squashed. NOP bubbles are
//   written into IF/ID and the ID/EX flush is raised on a taken branch.
//
//   Optional feature: define FETCH_REDIRECT_STATS_EN to build saturating
//   redirect/squash counters. Without it the stat_* ports read 16'h0000.
//
//   Ports
//     clk             rising-edge clock
//     rst_n           asynchronous reset, active-low
//     stall_i         load-use stall: hold IF/ID contents
//     br_taken_i      EX branch resolved taken
//     br_target_i     branch target (bits [1:0] ignored)
//     jump_i          ID stage decoded a jump
//     jump_target_i   jump target (bits [1:0] ignored)
//     imem            instruction-memory bus (master side)
//     if_id_pc_o      IF/ID PC
//     if_id_instr_o   IF/ID instruction
//     if_id_valid_o   IF/ID holds a real instruction
//     id_ex_flush_o   combinational: bubble ID/EX this cycle (= br_taken_i)
//     stat_br_cnt_o   cycles with a taken branch
//     stat_jmp_cnt_o  cycles with a jump not overridden by a branch
//     stat_sq_cnt_o   dropped responses / dropped skid entries
// ---------------------------------------------------------------------------
module fetch_redirect_stage #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall_i,
    input  logic                 br_taken_i,
    input  logic [XLEN-1:0]      br_target_i,
    input  logic                 jump_i,
    input  logic [XLEN-1:0]      jump_target_i,
    fetch_redirect_stage_if.master imem,
    output logic [XLEN-1:0]      if_id_pc_o,
    output logic [31:0]          if_id_instr_o,
    output logic                 if_id_valid_o,
    output logic                 id_ex_flush_o,
    output logic [15:0]          stat_br_cnt_o,
    output logic [15:0]          stat_jmp_cnt_o,
    output logic [15:0]          stat_sq_cnt_o
);

    localparam logic [XLEN-1:0] PC_INC = {{(XLEN-3){1'b0}}, 3'b100};

    typedef enum logic [2:0] {
        ST_BOOT   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_SQUASH = 3'd3,
        ST_HOLD   = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_req_q, pc_req_d;
    logic [XLEN-1:0] skid_pc_q, skid_pc_d;
    logic [31:0]     skid_instr_q, skid_instr_d;
    logic [XLEN-1:0] if_id_pc_q, if_id_pc_d;
    logic [31:0]     if_id_instr_q, if_id_instr_d;
    logic            if_id_valid_q, if_id_valid_d;

    logic            redirect_s;
    logic [XLEN-1:0] target_raw_s;
    logic [XLEN-1:0] target_s;
    logic            req_s;
    logic            resp_wr_s;
    logic [XLEN-1:0] resp_pc_s;
    logic [31:0]     resp_instr_s;
    logic            drop_s;
    logic            align_unused_s;

    // The branch is the older instruction, so it wins over a same-cycle jump.
    assign redirect_s     = br_taken_i | jump_i;
    assign target_raw_s   = br_taken_i ? br_target_i : jump_target_i;
    assign target_s       = {target_raw_s[XLEN-1:2], 2'b00};
    assign align_unused_s = ^target_raw_s[1:0];

    assign imem.req      = req_s;
    assign imem.addr     = pc_q;
    assign id_ex_flush_o = br_taken_i;

    // Fetch FSM next-state, PC and skid-buffer updates.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pc_req_d     = pc_req_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        req_s        = 1'b0;
        resp_wr_s    = 1'b0;
        resp_pc_s    = pc_req_q;
        resp_instr_s = imem.rdata;
        drop_s       = 1'b0;

        case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
            end

            ST_FETCH: begin
                if (redirect_s) begin
                    // Retarget without issuing; the request goes out next cycle.
                    pc_d = target_s;
                end else begin
                    req_s = 1'b1;
                    if (imem.gnt) begin
                        pc_req_d = pc_q;
                        state_d  = ST_WAIT;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end

            ST_WAIT: begin
                if (redirect_s) begin
                    pc_d = target_s;
                    if (imem.rvalid) begin
                        drop_s  = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        // Response still in flight: wait for it and throw it away.
                        state_d = ST_SQUASH;
                    end
                end else if (imem.rvalid) begin
                    if (stall_i) begin
                        // IF/ID is frozen; park the response until the stall clears.
                        skid_pc_d    = pc_req_q;
                        skid_instr_d = imem.rdata;
                        state_d      = ST_HOLD;
                    end else begin
                        resp_wr_s    = 1'b1;
                        resp_pc_s    = pc_req_q;
                        resp_instr_s = imem.rdata;
                        pc_d         = pc_req_q + PC_INC;
                        state_d      = ST_FETCH;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end

            ST_SQUASH: begin
                if (redirect_s) begin
                    pc_d = target_s;
                end else begin
                    pc_d = pc_q;
                end
                if (imem.rvalid) begin
                    drop_s  = 1'b1;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_SQUASH;
                end
            end

            ST_HOLD: begin
                if (redirect_s) begin
                    drop_s  = 1'b1;
                    pc_d    = target_s;
                    state_d = ST_FETCH;
                end else if (!stall_i) begin
                    resp_wr_s    = 1'b1;
                    resp_pc_s    = skid_pc_q;
                    resp_instr_s = skid_instr_q;
                    pc_d         = skid_pc_q + PC_INC;
                    state_d      = ST_FETCH;
                end else begin
                    state_d = ST_HOLD;
                end
            end

            default: begin
                // Unreachable encoding: restart cleanly from boot.
                state_d = ST_BOOT;
            end
        endcase
    end

    // IF/ID next value: redirect > stall > new response > bubble.
    always_comb begin
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_valid_d = if_id_valid_q;
        if (redirect_s) begin
            // Flush wins over stall: the instruction in IF/ID is wrong-path.
            if_id_instr_d = NOP_INSTR;
            if_id_valid_d = 1'b0;
        end else if (stall_i) begin
            if_id_valid_d = if_id_valid_q;
        end else if (resp_wr_s) begin
            if_id_pc_d    = resp_pc_s;
            if_id_instr_d = resp_instr_s;
            if_id_valid_d = 1'b1;
        end else begin
            if_id_instr_d = NOP_INSTR;
            if_id_valid_d = 1'b0;
        end
    end

    // State, PC, skid buffer and IF/ID registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            pc_req_q      <= {XLEN{1'b0}};
            skid_pc_q     <= {XLEN{1'b0}};
            skid_instr_q  <= 32'h0000_0000;
            if_id_pc_q    <= {XLEN{1'b0}};
            if_id_instr_q <= NOP_INSTR;
            if_id_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pc_req_q      <= pc_req_d;
            skid_pc_q     <= skid_pc_d;
            skid_instr_q  <= skid_instr_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_valid_q <= if_id_valid_d;
        end
    end

    assign if_id_pc_o    = if_id_pc_q;
    assign if_id_instr_o = if_id_instr_q;
    assign if_id_valid_o = if_id_valid_q;

`ifdef FETCH_REDIRECT_STATS_EN
    logic [15:0] stat_br_q;
    logic [15:0] stat_jmp_q;
    logic [15:0] stat_sq_q;

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        logic [15:0] r;
        if (en && (v != 16'hFFFF)) begin
            r = v + 16'd1;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Saturating redirect and squash counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_br_q  <= 16'h0000;
            stat_jmp_q <= 16'h0000;
            stat_sq_q  <= 16'h0000;
        end else begin
            stat_br_q  <= sat_inc(stat_br_q, br_taken_i);
            stat_jmp_q <= sat_inc(stat_jmp_q, jump_i & ~br_taken_i);
            stat_sq_q  <= sat_inc(stat_sq_q, drop_s);
        end
    end

    assign stat_br_cnt_o  = stat_br_q;
    assign stat_jmp_cnt_o = stat_jmp_q;
    assign stat_sq_cnt_o  = stat_sq_q;
`else
    logic stats_unused_s;
    assign stats_unused_s = drop_s;
    assign stat_br_cnt_o  = 16'h0000;
    assign stat_jmp_cnt_o = 16'h0000;
    assign stat_sq_cnt_o  = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_redirect_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_redirect_stage
//   Directed, table-driven bench for fetch_redirect_stage. Each table row is
//   one clock cycle: the memory/redirect inputs for that cycle and the
//   outputs expected at the falling edge of that cycle. A hand-written
//   sequence follows for reset in the middle of an outstanding fetch.
// ---------------------------------------------------------------------------
module tb_fetch_redirect_stage;

    localparam int XLEN = 32;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        id_ex_flush;
    logic [15:0] stat_br_cnt;
    logic [15:0] stat_jmp_cnt;
    logic [15:0] stat_sq_cnt;

    int total_checks;
    int passed_checks;

    fetch_redirect_stage_if #(.XLEN(XLEN)) bus ();

    fetch_redirect_stage #(
        .XLEN      (XLEN),
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall_i        (stall),
        .br_taken_i     (br_taken),
        .br_target_i    (br_target),
        .jump_i         (jump),
        .jump_target_i  (jump_target),
        .imem           (bus.master),
        .if_id_pc_o     (if_id_pc),
        .if_id_instr_o  (if_id_instr),
        .if_id_valid_o  (if_id_valid),
        .id_ex_flush_o  (id_ex_flush),
        .stat_br_cnt_o  (stat_br_cnt),
        .stat_jmp_cnt_o (stat_jmp_cnt),
        .stat_sq_cnt_o  (stat_sq_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] brt;
        logic        jmp;
        logic [31:0] jt;
        logic        gnt;
        logic        rv;
        logic [31:0] rd;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_flush;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_valid;
        logic [15:0] e_bc;
        logic [15:0] e_jc;
        logic [15:0] e_sc;
    } vec_t;

    vec_t vecs[$];

    // Instruction word the memory returns for a given address.
    function automatic logic [31:0] dat(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // Counter values only exist when the stats feature is built in.
    function automatic logic [15:0] exp_stat(input logic [15:0] v);
`ifdef FETCH_REDIRECT_STATS_EN
        return v;
`else
        return v & 16'h0000;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            passed_checks++;
        end
    endtask

    task automatic add(
        input logic st, input logic br, input logic [31:0] brt,
        input logic jmp, input logic [31:0] jt,
        input logic gnt, input logic rv, input logic [31:0] rd,
        input logic e_req, input logic [31:0] e_addr, input logic e_flush,
        input logic [31:0] e_pc, input logic [31:0] e_instr, input logic e_valid,
        input logic [15:0] e_bc, input logic [15:0] e_jc, input logic [15:0] e_sc);
        vec_t v;
        v.stall = st;  v.br = br;   v.brt = brt; v.jmp = jmp; v.jt = jt;
        v.gnt = gnt;   v.rv = rv;   v.rd = rd;
        v.e_req = e_req; v.e_addr = e_addr; v.e_flush = e_flush;
        v.e_pc = e_pc; v.e_instr = e_instr; v.e_valid = e_valid;
        v.e_bc = e_bc; v.e_jc = e_jc; v.e_sc = e_sc;
        vecs.push_back(v);
    endtask

    task automatic drive_idle();
        stall = 1'b0; br_taken = 1'b0; br_target = 32'h0; jump = 1'b0; jump_target = 32'h0;
        bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = JUNK;
    endtask

    initial begin
        total_checks  = 0;
        passed_checks = 0;

        //   st br brt          j  jt           g  rv rdata              | req addr          fl pc           instr              v  bc     jc     sc
        add(0, 0, 32'h0,      0, 32'h0,      0, 0, JUNK,              0, 32'h0,        0, 32'h0,      NOP,               0, 16'd0, 16'd0, 16'd0); // 0  BOOT
        add(0, 0, 32'h0,      0, 32'h0,      1, 0, JUNK,              1, 32'h0,        0, 32'h0,      NOP,               0, 16'd0, 16'd0, 16'd0); // 1  req 0x0
        add(0, 0, 32'h0,      0, 32'h0,      0, 1, dat(32'h0),        0, 32'h0,        0, 32'h0,      NOP,               0, 16'd0, 16'd0, 16'd0); // 2  resp 0x0
        add(0, 0, 32'h0,      0, 32'h0,      1, 0, JUNK,              1, 32'h4,        0, 32'h0,      dat(32'h0),        1, 16'd0, 16'd0, 16'd0); // 3  req 0x4
        add(0, 0, 32'h0,      0, 32'h0,      0, 1, dat(32'h4),        0, 32'h4,        0, 32'h0,      NOP,               0, 16'd0, 16'd0, 16'd0); // 4  resp 0x4
        add(0, 0, 32'h0,      0, 32'h0,      1, 0, JUNK,              1, 32'h8,        0, 32'h4,      dat(32'h4),        1, 16'd0, 16'd0, 16'd0); // 5  req 0x8
        add(0, 1, 32'h40,     0, 32'h0,      0, 0, JUNK,              0, 32'h8,        1, 32'h4,      NOP,               0, 16'd0, 16'd0, 16'd0); // 6  branch in WAIT
        add(0, 0, 32'h0,      0, 32'h0,      0, 1, dat(32'h8),        0, 32'h40,       0, 32'h4,      NOP,               0, 16'd1, 16'd0, 16'd0); // 7  squash 0x8
        add(0, 0, 32'h0,      0, 32'h0,      1, 0, JUNK,              1, 32'h40,       0, 32'h4,      NOP,               0, 16'd1, 16'd0, 16'd1); // 8  req 0x40
        add(0, 1, 32'h40,     1, 32'h80,     0, 1, dat(32'h40),       0, 32'h40,       1, 32'h4,      NOP,               0, 16'd1, 16'd0, 16'd1); // 9  br+jmp+rvalid
        add(0, 0, 32'h0,      0, 32'h0,      1, 0, JUNK,              1, 32'h40,       0, 32'h4,      NOP,               0, 16'd2, 16'd0, 16'd2); // 10 req 0x40
        add(1, 0, 32'h0,      0, 32'h0,      0, 1, dat(32'h40),       0, 32'h40,       0, 32'h4,      NOP,               0, 16'd2, 16'd0, 16'd2); // 11 resp under stall
        add(1, 0, 32'h0,      0, 32'h0,      0, 0, JUNK,              0, 32'h40,       0, 32'h4,      NOP,               0, 16'd2, 16'd0, 16'd2); // 12 HOLD
        add(1, 0, 32'h0,      0, 32'h0,      0, 0, JUNK,              0, 32'h40,       0, 32'h4,      NOP,               0, 16'd2, 16'd0, 16'd2); // 13 HOLD
        add(0, 0, 32'h0,      0, 32'h0,      0, 0, JUNK,              0, 32'h40,       0, 32'h4,      NOP,               0, 16'd2, 16'd0, 16'd2); // 14 stall drops
        add(0, 0, 32'h0,      0, 32'h0,      0, 0, JUNK,              1, 32'h44,       0, 32'h40,     dat(32'h40),       1, 16'd2, 16'd0, 16'd2); // 15 no grant
        add(0, 0, 32'h0,      0, 32'h0,      1, 0, JUNK,              1, 32'h44,       0, 32'h40,     NOP,               0, 16'd2, 16'd0, 16'd2); // 16 req 0x44
        add(0, 0, 32'h0,      0, 32'h0,      0, 0, JUNK,              0, 32'h44,       0, 32'h40,     NOP,               0, 16'd2, 16'd0, 16'd2); // 17 latency 2
        add(1, 0, 32'h0,      0, 32'h0,      0, 1, dat(32'h44),       0, 32'h44,       0, 32'h40,     NOP,               0, 16'd2, 16'd0, 16'd2); // 18 resp under stall
        add(1, 1, 32'h203,    0, 32'h0,      0, 0, JUNK,              0, 32'h44,       1, 32'h40,     NOP,               0, 16'd2, 16'd0, 16'd2); // 19 branch in HOLD
        add(0, 0, 32'h0,      1, 32'h300,    0, 0, JUNK,              0, 32'h200,      0, 32'h40,     NOP,               0, 16'd3, 16'd0, 16'd3); // 20 jump in FETCH
        add(0, 0, 32'h0,      0, 32'h0,      1, 0, JUNK,              1, 32'h300,      0, 32'h40,     NOP,               0, 16'd3, 16'd1, 16'd3); // 21 req 0x300
        add(0, 0, 32'h0,      0, 32'h0,      0, 1, dat(32'h300),      0, 32'h300,      0, 32'h40,     NOP,               0, 16'd3, 16'd1, 16'd3); // 22 resp 0x300
        add(1, 0, 32'h0,      0, 32'h0,      0, 0, JUNK,              1, 32'h304,      0, 32'h300,    dat(32'h300),      1, 16'd3, 16'd1, 16'd3); // 23 stall holds valid
        add(0, 0, 32'h0,      0, 32'h0,      0, 0, JUNK,              1, 32'h304,      0, 32'h300,    dat(32'h300),      1, 16'd3, 16'd1, 16'd3); // 24 bubble
        add(0, 0, 32'h0,      0, 32'h0,      0, 0, JUNK,              1, 32'h304,      0, 32'h300,    NOP,               0, 16'd3, 16'd1, 16'd3); // 25
        add(0, 0, 32'h0,      1, 32'hFFFF_FFFE, 0, 0, JUNK,           0, 32'h304,      0, 32'h300,    NOP,               0, 16'd3, 16'd1, 16'd3); // 26 jump to top
        add(0, 0, 32'h0,      0, 32'h0,      1, 0, JUNK,              1, 32'hFFFF_FFFC, 0, 32'h300,   NOP,               0, 16'd3, 16'd2, 16'd3); // 27 req top
        add(0, 0, 32'h0,      0, 32'h0,      0, 1, dat(32'hFFFF_FFFC), 0, 32'hFFFF_FFFC, 0, 32'h300,  NOP,               0, 16'd3, 16'd2, 16'd3); // 28 resp top
        add(0, 0, 32'h0,      0, 32'h0,      0, 0, JUNK,              1, 32'h0,        0, 32'hFFFF_FFFC, dat(32'hFFFF_FFFC), 1, 16'd3, 16'd2, 16'd3); // 29 pc wrapped

        // Reset state.
        drive_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset req",   {31'd0, bus.req},     32'h0);
        chk("reset addr",  bus.addr,             32'h0);
        chk("reset pc",    if_id_pc,             32'h0);
        chk("reset instr", if_id_instr,          NOP);
        chk("reset valid", {31'd0, if_id_valid}, 32'h0);
        chk("reset stats", {stat_br_cnt, stat_jmp_cnt | stat_sq_cnt}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // One table row per cycle: drive after the rising edge, check on the falling edge.
        for (int i = 0; i < vecs.size(); i++) begin
            stall       = vecs[i].stall;
            br_taken    = vecs[i].br;
            br_target   = vecs[i].brt;
            jump        = vecs[i].jmp;
            jump_target = vecs[i].jt;
            bus.gnt     = vecs[i].gnt;
            bus.rvalid  = vecs[i].rv;
            bus.rdata   = vecs[i].rd;
            @(negedge clk);
            chk($sformatf("row%0d req", i),   {31'd0, bus.req},     {31'd0, vecs[i].e_req});
            chk($sformatf("row%0d addr", i),  bus.addr,             vecs[i].e_addr);
            chk($sformatf("row%0d flush", i), {31'd0, id_ex_flush}, {31'd0, vecs[i].e_flush});
            chk($sformatf("row%0d pc", i),    if_id_pc,             vecs[i].e_pc);
            chk($sformatf("row%0d instr", i), if_id_instr,          vecs[i].e_instr);
            chk($sformatf("row%0d valid", i), {31'd0, if_id_valid}, {31'd0, vecs[i].e_valid});
            chk($sformatf("row%0d br_cnt", i),  {16'd0, stat_br_cnt},  {16'd0, exp_stat(vecs[i].e_bc)});
            chk($sformatf("row%0d jmp_cnt", i), {16'd0, stat_jmp_cnt}, {16'd0, exp_stat(vecs[i].e_jc)});
            chk($sformatf("row%0d sq_cnt", i),  {16'd0, stat_sq_cnt},  {16'd0, exp_stat(vecs[i].e_sc)});
            @(posedge clk);
            #1;
        end

        // Reset while a fetch is outstanding; the late response must be ignored.
        drive_idle();
        bus.gnt = 1'b1;
        @(negedge clk);
        chk("mid req issued", {31'd0, bus.req}, 32'h1);
        @(posedge clk);
        #1;
        drive_idle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset req",   {31'd0, bus.req},     32'h0);
        chk("async reset valid", {31'd0, if_id_valid}, 32'h0);
        chk("async reset instr", if_id_instr,          NOP);
        chk("async reset stats", {stat_br_cnt, stat_jmp_cnt | stat_sq_cnt}, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.rvalid = 1'b1;
        bus.rdata  = 32'hBAD0_0000;
        @(negedge clk);
        chk("boot no req", {31'd0, bus.req}, 32'h0);
        @(posedge clk);
        #1;
        bus.rvalid = 1'b0;
        bus.rdata  = JUNK;
        @(negedge clk);
        chk("post boot req",   {31'd0, bus.req},     32'h1);
        chk("post boot addr",  bus.addr,             32'h0);
        chk("late resp ignored", {31'd0, if_id_valid}, 32'h0);
        bus.gnt = 1'b1;
        @(posedge clk);
        #1;
        bus.gnt    = 1'b0;
        bus.rvalid = 1'b1;
        bus.rdata  = dat(32'h0);
        @(posedge clk);
        #1;
        bus.rvalid = 1'b0;
        bus.rdata  = JUNK;
        @(negedge clk);
        chk("refetch valid", {31'd0, if_id_valid}, 32'h1);
        chk("refetch pc",    if_id_pc,             32'h0);
        chk("refetch instr", if_id_instr,          dat(32'h0));
        chk("refetch addr",  bus.addr,             32'h4);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
